// File: rtl/stage_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues in-order requests to
// instruction memory, buffers responses and drives the IF/DE pipeline register.
module stage_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_stall,
   input  logic        de_clear,
   input  logic        ex_pc_src,
   input  logic [31:0] ex_pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] de_instr,
   output logic [31:0] de_pc,
   output logic [31:0] de_pc_plus4
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rq_pc_q [DEPTH];
   logic [PW-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
   logic [31:0]   bf_pc_q [DEPTH];
   logic [31:0]   bf_instr_q [DEPTH];
   logic [PW-1:0] bf_wr_q, bf_wr_d, bf_rd_q, bf_rd_d;
   logic [CW-1:0] bf_cnt_q, bf_cnt_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [31:0]   de_instr_q, de_instr_d;
   logic [31:0]   de_pc_q, de_pc_d;
   logic [31:0]   de_pc_plus4_q, de_pc_plus4_d;

   logic room, req_fire, resp_keep, advance, bf_empty, bf_pop, bypass, bf_push;
   logic unused_tgt_lsb;

   // Request channel: a request transfers on a cycle where imem_req && imem_ready;
   // imem_req/imem_addr stay stable until then. Responses are in order and always accepted.
   assign room      = ({1'b0, out_q} + {1'b0, bf_cnt_q}) < DEPTH_C;
   assign imem_req  = !rst && !ex_pc_src && room;
   assign imem_addr = fetch_pc_q;
   assign req_fire  = imem_req && imem_ready;

   assign resp_keep = imem_rvalid && (disc_q == '0) && !ex_pc_src;
   // de_clear consumes the candidate instruction even while stalled, then loads a bubble.
   assign advance   = de_clear || !de_stall;
   assign bf_empty  = (bf_cnt_q == '0);
   assign bf_pop    = advance && !bf_empty && !ex_pc_src;
   assign bypass    = advance && bf_empty && resp_keep;
   assign bf_push   = resp_keep && !bypass;

   assign unused_tgt_lsb = ^ex_pc_target[1:0];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rq_wr_d    = rq_wr_q + PW'(req_fire);
      rq_rd_d    = rq_rd_q + PW'(imem_rvalid);
      out_d      = out_q + CW'(req_fire) - CW'(imem_rvalid);
      disc_d     = disc_q;
      bf_wr_d    = bf_wr_q + PW'(bf_push);
      bf_rd_d    = bf_rd_q + PW'(bf_pop);
      bf_cnt_d   = bf_cnt_q + CW'(bf_push) - CW'(bf_pop);

      if (ex_pc_src) begin
         fetch_pc_d = {ex_pc_target[31:2], 2'b00};
         disc_d     = out_q - CW'(imem_rvalid);
         bf_rd_d    = bf_wr_q;
         bf_cnt_d   = '0;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_rvalid && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
         end
      end
   end

   always_comb begin
      de_instr_d    = de_instr_q;
      de_pc_d       = de_pc_q;
      de_pc_plus4_d = de_pc_plus4_q;
      if (ex_pc_src || de_clear) begin
         de_instr_d    = NOP_INSTR;
         de_pc_d       = 32'd0;
         de_pc_plus4_d = 32'd0;
      end else if (de_stall) begin
         de_instr_d    = de_instr_q;
      end else if (!bf_empty) begin
         de_instr_d    = bf_instr_q[bf_rd_q];
         de_pc_d       = bf_pc_q[bf_rd_q];
         de_pc_plus4_d = bf_pc_q[bf_rd_q] + 32'd4;
      end else if (resp_keep) begin
         de_instr_d    = imem_rdata;
         de_pc_d       = rq_pc_q[rq_rd_q];
         de_pc_plus4_d = rq_pc_q[rq_rd_q] + 32'd4;
      end else begin
         de_instr_d    = NOP_INSTR;
         de_pc_d       = 32'd0;
         de_pc_plus4_d = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         rq_wr_q       <= '0;
         rq_rd_q       <= '0;
         bf_wr_q       <= '0;
         bf_rd_q       <= '0;
         bf_cnt_q      <= '0;
         out_q         <= '0;
         disc_q        <= '0;
         de_instr_q    <= NOP_INSTR;
         de_pc_q       <= 32'd0;
         de_pc_plus4_q <= 32'd0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rq_wr_q       <= rq_wr_d;
         rq_rd_q       <= rq_rd_d;
         bf_wr_q       <= bf_wr_d;
         bf_rd_q       <= bf_rd_d;
         bf_cnt_q      <= bf_cnt_d;
         out_q         <= out_d;
         disc_q        <= disc_d;
         de_instr_q    <= de_instr_d;
         de_pc_q       <= de_pc_d;
         de_pc_plus4_q <= de_pc_plus4_d;
      end
   end

   // Storage arrays carry no reset; their contents are qualified by the pointers.
   always_ff @(posedge clk) begin
      if (!rst && req_fire) begin
         rq_pc_q[rq_wr_q] <= fetch_pc_q;
      end
      if (!rst && bf_push) begin
         bf_pc_q[bf_wr_q]    <= rq_pc_q[rq_rd_q];
         bf_instr_q[bf_wr_q] <= imem_rdata;
      end
   end

   assign de_instr    = de_instr_q;
   assign de_pc       = de_pc_q;
   assign de_pc_plus4 = de_pc_plus4_q;

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
Instruction fetch stage and producer of the IF/DE pipeline register consumed by the decode stage (de_instr, de_pc, de_pc_plus4).
- Keeps the fetch PC and issues requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small FIFO, so variable memory latency does not stall the core.
- Handles decode stall, decode flush and execute-stage branch/jump redirection, and discards responses to requests issued before a redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
DEPTH, 2, instruction buffer entries and maximum outstanding requests (power of 2, ≥2).
NOP_INSTR, 32'h0000_0000, encoding driven on de_instr for a bubble (decodes with no side effects).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
de_stall  in  1  hold the IF/DE register (hazard unit)
de_clear  in  1  load a bubble into the IF/DE register
ex_pc_src  in  1  taken branch/jump from execute; redirect fetch
ex_pc_target  in  32  redirect target
imem_req  out  1  request valid
imem_addr  out  32  request word address (bits [1:0] always 00)
imem_ready  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response valid (in order, ≥1 cycle after acceptance)
imem_rdata  in  32  response instruction
de_instr  out  32  IF/DE instruction
de_pc  out  32  IF/DE PC
de_pc_plus4  out  32  IF/DE PC+4

Behaviour:
- State:
  - fetch_pc.
  - Request-PC queue and instruction buffer, each DEPTH entries of {pc, instr}.
  - outstanding counter (0..DEPTH).
  - discard counter (0..DEPTH).
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; buffer, queue, outstanding and discard cleared.
  - de_instr=NOP_INSTR, de_pc=0, de_pc_plus4=0.
  - imem_req=0 while rst is high.
  - The memory resets on the same rst; responses to pre-reset requests are illegal.
- Issue:
  - imem_req = !rst && !ex_pc_src && (outstanding + buffer_count) < DEPTH.
  - imem_addr = fetch_pc.
  - On imem_req && imem_ready: push fetch_pc into the request queue, outstanding++, fetch_pc += 4 (mod 2^32).
  - imem_req/imem_addr are held until the request is accepted.
- Response, on imem_rvalid:
  - Pop the request queue; outstanding--.
  - If discard>0: drop the response, discard--.
  - Otherwise write {queued pc, imem_rdata} into the buffer, or bypass it directly into IF/DE when the buffer is empty and IF/DE is loading this cycle.
  - Overflow is impossible by the issue rule.
- Redirect, on ex_pc_src=1:
  - fetch_pc = {ex_pc_target[31:2], 2'b00}.
  - Buffer flushed; no request issued this cycle.
  - discard = outstanding after this cycle's accounting; a response arriving in the same cycle is dropped.
- IF/DE register update priority, evaluated at each edge:
  1. rst → reset values above.
  2. ex_pc_src or de_clear → bubble: NOP_INSTR, pc 0, pc_plus4 0.
  3. de_stall → hold all outputs; buffer is not popped, but responses are still accepted.
  4. Buffer non-empty → pop head.
  5. Valid non-discarded response this cycle → bypass load.
  6. Otherwise → bubble.
- Outputs:
  - de_pc_plus4 = de_pc + 4, computed at load, 32-bit wrap (e.g. 0xFFFFFFFC → 0x0).
  - Bubble rows carry pc 0 and pc_plus4 0.
- Latency: request accepted at cycle N with response at N+1 → instruction on de_instr after the edge ending N+1.
- Throughput: one instruction per cycle with 1-cycle memory and imem_ready=1.
- Ordering: no PC is skipped or duplicated across stalls, ready back-pressure or buffer-full.
- de_clear alone does not redirect fetch; the buffered instruction is consumed and replaced by the bubble.

Test Plan:
1. RESET_PC=0, memory latency 1, ready=1, mem[i]=0xA0000000+i → de_pc 0,4,8,12 on consecutive cycles, de_instr 0xA0000000.., de_pc_plus4 4,8,12,16.
2. imem_ready=0 for 3 cycles at addr 0x8 → imem_addr held at 0x8, imem_req=1 throughout; buffer drains, then NOP_INSTR bubbles; sequence resumes at pc 0x8, no gap.
3. de_stall=1 for 2 cycles while de_pc=0x10 → outputs hold 0x10; imem_req drops once the buffer is full; after release de_pc 0x14, 0x18 with no loss.
4. Latency 3 with 2 outstanding, ex_pc_src=1 with target 0x100 → bubble next cycle; both stale responses dropped; next valid row de_pc=0x100 with mem[0x100] data.
5. ex_pc_src=1 with imem_rvalid=1 and de_stall=1 in the same cycle → redirect wins: bubble loaded, response dropped, imem_req=0 that cycle.
6. Redirect to 0xFFFFFFFF → fetch address 0xFFFFFFFC, de_pc_plus4=0x0, next fetch 0x0. Then rst pulsed mid-stream → outputs NOP/0/0, fetch restarts at RESET_PC.
